// File: rtl/pipe_gap_sampler.sv
// ---------------------------------------------------------------------------
// pipe_gap_sampler
//
// Purpose:
//   Consumer end of the random-byte interface. It samples the 8-bit random
//   stream, turns accepted samples into bounded pipe-gap Y coordinates, and
//   keeps them in a small prefetch FIFO for the pipe scroller. Out-of-range
//   samples are retried up to MAX_TRIES times; the last try always produces
//   a value by folding the sample back into range. Rejected samples and
//   player flaps are fed back to the generator through `change` to stir it.
//
// Ports:
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   random_256 in   8   random byte from the generator (changes every cycle)
//   change     out  1   registered stir bit: flap | reject, one cycle later
//   flap       in   1   player flap level/pulse
//   pop        in   1   scroller consumes the FIFO head
//   gap_y      out 10   FIFO head value, meaningful only while gap_valid=1
//   gap_valid  out  1   FIFO not empty
//   reject_cnt out  8   saturating count of rejected samples
//
// Build option:
//   PIPE_GAP_STATS_EN - when defined, reject_cnt counts every rejected
//   sample (fallback samples included) and saturates at 255. When undefined
//   the counter is not built and reject_cnt is tied to 0.
//
// Handshake: gap_valid/pop act as valid/ready on the FIFO head. An entry is
// transferred on a rising clk edge where gap_valid=1 and pop=1; pop while
// gap_valid=0 has no effect. gap_y is stable until it is transferred.
// ---------------------------------------------------------------------------
module pipe_gap_sampler #(
    parameter int GAP_MIN   = 80,
    parameter int GAP_RANGE = 200,
    parameter int MAX_TRIES = 4,
    parameter int SKIP      = 3,
    parameter int FIFO_AW   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  random_256,
    output logic        change,
    input  logic        flap,
    input  logic        pop,
    output logic [9:0]  gap_y,
    output logic        gap_valid,
    output logic [7:0]  reject_cnt
);

    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [FIFO_AW:0] DEPTH_C     = (FIFO_AW+1)'(DEPTH);
    localparam logic [9:0]       GAP_MIN_C   = 10'(GAP_MIN);
    localparam logic [9:0]       GAP_RANGE_C = 10'(GAP_RANGE);
    localparam logic [3:0]       MAX_TRIES_C = 4'(MAX_TRIES);
    localparam logic [3:0]       SKIP_C      = 4'(SKIP);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAW  = 2'd1;
    localparam logic [1:0] S_SKIPW = 2'd2;

    logic [1:0]         state;
    logic [3:0]         tries;
    logic [3:0]         skip_cnt;

    logic [9:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW:0]   count;

    logic [9:0]         sample_v;
    logic               accept;
    logic               last_try;
    logic               push;
    logic               do_pop;
    logic               reject_pulse;
    logic [9:0]         push_val;

    always_comb begin
        sample_v     = {2'b00, random_256};
        accept       = (sample_v < GAP_RANGE_C);
        last_try     = ((tries + 4'd1) == MAX_TRIES_C);
        push         = (state == S_DRAW) && (accept || last_try);
        reject_pulse = (state == S_DRAW) && !accept;
        // Fallback folds a rejected sample back into range; with
        // GAP_RANGE >= 128 the difference is always below GAP_RANGE.
        push_val     = accept ? (GAP_MIN_C + sample_v)
                              : (GAP_MIN_C + (sample_v - GAP_RANGE_C));
        do_pop       = pop && (count != '0);
    end

    // Sampling FSM: IDLE waits for FIFO space, DRAW takes one sample,
    // SKIPW lets the shift stream move on before the next sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tries    <= '0;
            skip_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (count < DEPTH_C) state <= S_DRAW;
                end
                S_DRAW: begin
                    if (push) tries <= '0;
                    else      tries <= tries + 4'd1;
                    skip_cnt <= SKIP_C;
                    state    <= S_SKIPW;
                end
                S_SKIPW: begin
                    if (skip_cnt == '0) state <= S_IDLE;
                    else                skip_cnt <= skip_cnt - 4'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Prefetch FIFO. Pushes come only from DRAW, which is entered only when
    // not full, so no overflow guard is needed on the write side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_val;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign gap_y     = mem[rd_ptr];
    assign gap_valid = (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) change <= 1'b0;
        else        change <= flap | reject_pulse;
    end

`ifdef PIPE_GAP_STATS_EN
    logic [7:0] rej_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              rej_q <= '0;
        else if (reject_pulse && rej_q != 8'hFF) rej_q <= rej_q + 8'd1;
    end
    assign reject_cnt = rej_q;
`else
    assign reject_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pipe_gap_sampler.sv
// ---------------------------------------------------------------------------
// tb_pipe_gap_sampler
//
// Directed and randomized bench for pipe_gap_sampler. A behavioural model
// tracks the FIFO contents as a queue and predicts sample instants from the
// sample spacing rule (one IDLE check, DRAW, SKIP+1 wait cycles), then the
// accept / retry / fallback rules decide what each sample pushes.
// ---------------------------------------------------------------------------
module tb_pipe_gap_sampler;

    localparam int GAP_MIN   = 80;
    localparam int GAP_RANGE = 200;
    localparam int MAX_TRIES = 4;
    localparam int SKIP      = 3;
    localparam int FIFO_AW   = 2;
    localparam int DEPTH     = 1 << FIFO_AW;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] random_256;
    logic       change;
    logic       flap;
    logic       pop;
    logic [9:0] gap_y;
    logic       gap_valid;
    logic [7:0] reject_cnt;

    pipe_gap_sampler #(
        .GAP_MIN  (GAP_MIN),
        .GAP_RANGE(GAP_RANGE),
        .MAX_TRIES(MAX_TRIES),
        .SKIP     (SKIP),
        .FIFO_AW  (FIFO_AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .random_256(random_256),
        .change    (change),
        .flap      (flap),
        .pop       (pop),
        .gap_y     (gap_y),
        .gap_valid (gap_valid),
        .reject_cnt(reject_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    logic [9:0] exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         t;          // edges since reset release
    int         check_at;   // edge at which the sampler next looks for space
    int         draw_at;    // edge at which the next sample is taken
    int         tries_m;
    int         rej_m;
    logic       chg_m;
    logic       drew;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rc();
`ifdef PIPE_GAP_STATS_EN
        return (rej_m > 255) ? 32'd255 : 32'(rej_m);
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        exp_q.delete();
        t        = 0;
        check_at = 1;
        draw_at  = -1;
        tries_m  = 0;
        rej_m    = 0;
        chg_m    = 1'b0;
        drew     = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Called #1 after an edge: drive inputs, advance one edge, update model,
    // then compare outputs #1 after that edge.
    task automatic step(input logic f, input logic p, input logic [7:0] r);
        int         pre;
        logic       do_push;
        logic       rej;
        logic [9:0] val;
        flap       = f;
        pop        = p;
        random_256 = r;
        @(posedge clk);
        t++;
        pre     = exp_q.size();
        do_push = 1'b0;
        rej     = 1'b0;
        val     = '0;
        drew    = 1'b0;
        if (t == draw_at) begin
            drew = 1'b1;
            if (int'(r) < GAP_RANGE) begin
                do_push = 1'b1;
                val     = 10'(GAP_MIN + int'(r));
                tries_m = 0;
            end else begin
                rej = 1'b1;
                rej_m++;
                if (tries_m + 1 < MAX_TRIES) begin
                    tries_m++;
                end else begin
                    do_push = 1'b1;
                    val     = 10'(GAP_MIN + int'(r) - GAP_RANGE);
                    tries_m = 0;
                end
            end
        end else if (t == check_at) begin
            if (pre < DEPTH) begin
                draw_at  = t + 1;
                check_at = t + SKIP + 3;
            end else begin
                check_at = t + 1;
            end
        end
        chg_m = f | rej;
        if (p && pre > 0) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(val);
        #1;
        chk("gap_valid", 32'(gap_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("gap_y", 32'(gap_y), 32'(exp_q[0]));
        chk("change", 32'(change), 32'(chg_m));
        chk("reject_cnt", 32'(reject_cnt), exp_rc());
    endtask

    // Hold the current value until the model reports a sample was taken.
    task automatic sample(input logic [7:0] v, input logic pop_on_draw);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, pop_on_draw && (t + 1 == draw_at), v);
            if (drew) break;
        end
        chk("sample_taken", 32'(drew), 32'd1);
    endtask

    task automatic apply_reset(input logic [7:0] r);
        rst_n      = 1'b0;
        flap       = 1'b0;
        pop        = 1'b0;
        random_256 = r;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gap_valid", 32'(gap_valid), 32'd0);
        chk("rst_change", 32'(change), 32'd0);
        chk("rst_gap_y", 32'(gap_y), 32'd0);
        chk("rst_reject_cnt", 32'(reject_cnt), 32'd0);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        flap       = 1'b0;
        pop        = 1'b0;
        random_256 = 8'd0;
        model_reset();

        // Reset / first push latency
        apply_reset(8'd50);
        step(1'b0, 1'b0, 8'd50);
        chk("first_push_not_yet", 32'(gap_valid), 32'd0);
        step(1'b0, 1'b0, 8'd50);
        chk("first_push_valid", 32'(gap_valid), 32'd1);
        chk("first_push_y", 32'(gap_y), 32'd130);

        // Fill and stall: stalled sampler must not draw (250 would reject)
        apply_reset(8'd10);
        repeat (4) sample(8'd10, 1'b0);
        repeat (30) step(1'b0, 1'b0, 8'd250);
        chk("fill_valid", 32'(gap_valid), 32'd1);
        chk("fill_head", 32'(gap_y), 32'd90);

        // Fallback after MAX_TRIES rejects
        apply_reset(8'd250);
        repeat (4) sample(8'd250, 1'b0);
        step(1'b0, 1'b0, 8'd250);
        chk("fallback_head", 32'(gap_y), 32'd130);
`ifdef PIPE_GAP_STATS_EN
        chk("fallback_rejcnt", 32'(reject_cnt), 32'd4);
`else
        chk("fallback_rejcnt", 32'(reject_cnt), 32'd0);
`endif

        // Reject then accept, then a full set of retries again
        step(1'b0, 1'b1, 8'd5);
        sample(8'd220, 1'b0);
        sample(8'd199, 1'b0);
        step(1'b0, 1'b0, 8'd0);
        chk("rej_acc_head", 32'(gap_y), 32'd279);
        repeat (3) sample(8'd250, 1'b0);
        chk("tries_cleared_len", 32'(exp_q.size()), 32'd1);
        sample(8'd250, 1'b0);

        // Pop boundaries: empty pop, then push and pop together
        apply_reset(8'd60);
        step(1'b0, 1'b1, 8'd60);
        chk("empty_pop", 32'(gap_valid), 32'd0);
        step(1'b0, 1'b0, 8'd60);
        chk("one_entry_head", 32'(gap_y), 32'd140);
        sample(8'd70, 1'b1);
        chk("pushpop_valid", 32'(gap_valid), 32'd1);
        chk("pushpop_head", 32'(gap_y), 32'd150);
        step(1'b0, 1'b1, 8'd0);
        chk("pushpop_count1", 32'(gap_valid), 32'd0);

        // Flap held for three cycles
        step(1'b1, 1'b0, 8'd10);
        chk("flap_c1", 32'(change), 32'd1);
        step(1'b1, 1'b0, 8'd10);
        step(1'b1, 1'b0, 8'd10);
        step(1'b0, 1'b0, 8'd10);

        // Randomized traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 8'($urandom_range(0, 255)));

        // Reset in the middle of the wait phase with two entries queued
        apply_reset(8'd20);
        sample(8'd20, 1'b0);
        sample(8'd30, 1'b0);
        step(1'b0, 1'b0, 8'd30);
        chk("pre_reset_valid", 32'(gap_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", 32'(gap_valid), 32'd0);
        chk("mid_reset_change", 32'(change), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 8'd50);
        step(1'b0, 1'b0, 8'd50);
        chk("restart_head", 32'(gap_y), 32'd130);
        repeat (10) step(1'b0, 1'b0, 8'd210);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_gap_sampler.md
Name: pipe_gap_sampler

Overview:
- Consumer end of the random-byte interface.
- Samples the 8-bit random stream and feeds the generator's `change` stir input from player flaps and rejected samples.
- Converts accepted samples to bounded pipe-gap Y coordinates by rejection sampling with a bounded retry count.
- Buffers the coordinates in a small prefetch FIFO that the pipe scroller pops when a new pipe spawns.

Parameters:
- GAP_MIN, 80: pixel offset added to every accepted sample. GAP_MIN+255 must be ≤ 1023.
- GAP_RANGE, 200: samples < GAP_RANGE are accepted. Legal range is 128..256.
- MAX_TRIES, 4: number of samples per draw, including the final fallback sample. Legal range is 1..15.
- SKIP, 3: idle cycles after every sample before the next sample, to decorrelate the shift stream. Legal range is 0..15.
- FIFO_AW, 2: FIFO address width. Depth = 2**FIFO_AW.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- random_256, in, 8: random byte from the generator. Treated as changing every cycle.
- change, out, 1: stir bit to the generator.
- flap, in, 1: player flap level/pulse. Mixed into `change`.
- pop, in, 1: scroller consumes the FIFO head.
- gap_y, out, 10: FIFO head value. Valid only while gap_valid=1.
- gap_valid, out, 1: FIFO not empty.
- reject_cnt, out, 8: saturating count of rejected samples (see Optional Feature).

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values: FIFO empty; gap_valid=0; gap_y=0; change=0; reject_cnt=0; tries=0; skip counter=0; FSM=IDLE.
- State IDLE:
  - Go to DRAW when count < depth.
  - Stay in IDLE when the FIFO is full.
- State DRAW (exactly one cycle), sampling v=random_256:
  - Accept (v < GAP_RANGE): push GAP_MIN+v; clear tries.
  - Reject, tries+1 < MAX_TRIES: no push; tries++; set reject_pulse.
  - Reject, tries+1 = MAX_TRIES (fallback): push GAP_MIN+(v−GAP_RANGE); clear tries; set reject_pulse. The fallback value is always < GAP_RANGE because GAP_RANGE ≥ 128.
  - Always go to SKIPW next, loading the skip counter with SKIP.
- State SKIPW:
  - Decrement the skip counter each cycle.
  - At 0, go to IDLE.
  - With SKIP=0, SKIPW lasts one cycle.
- Sample spacing under a non-full FIFO is SKIP+3 cycles (DRAW, SKIP+1 cycles of SKIPW, IDLE).
- Latency: a push in the DRAW cycle makes gap_valid/gap_y visible the next cycle. The first DRAW occurs 2 cycles after reset release (the IDLE cycle, then DRAW).
- Arithmetic: 10-bit unsigned. No overflow is possible under the legal parameter ranges.
- FIFO:
  - gap_y is the registered head.
  - pop with gap_valid=1 removes the head. The next entry appears the following cycle.
  - pop with gap_valid=0 is ignored; no underflow, no state change.
  - A push and a pop in the same cycle leave count unchanged, and the pushed value is queued behind the head.
  - A push can occur only from DRAW, which is entered only when not full, so no overflow is possible.
  - Pointers wrap modulo depth.
- change is registered: change <= flap | reject_pulse, one cycle after the cause.
  - A flap and a reject in the same cycle give a single 1.
  - A held flap keeps change=1.
- Reset asserted mid-draw or mid-skip: everything returns immediately to the reset values. Queued entries are lost.
- tries persists across IDLE and SKIPW and is cleared only by a push or by reset.

Optional Feature:
- Macro PIPE_GAP_STATS_EN.
- When defined:
  - reject_cnt increments by 1 on every reject sample, including fallback samples.
  - reject_cnt saturates at 255.
  - reject_cnt is cleared only by reset.
- When undefined:
  - The counter logic is not built.
  - reject_cnt is driven constant 0.
  - All other behaviour is identical.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst_n=0, then release with random_256=50 held and pop=0.
  - Required: gap_valid=0 and change=0 during reset. gap_valid rises on cycle 3 after release with gap_y=130.
- Fill and stall:
  - Stimulus: random_256=10 held, pop=0, default parameters.
  - Required: 4 pushes spaced 6 cycles apart, then the FSM parks in IDLE. gap_valid stays 1, gap_y=90, with no further DRAW.
- Fallback:
  - Stimulus: random_256=250 held.
  - Required: 4 samples; change pulses 1 cycle after each sample. The 4th sample pushes 130. reject_cnt=4 with STATS_EN, 0 without.
- Reject then accept:
  - Stimulus: drive 220 at sample 1 and 199 at sample 2.
  - Required: single push of gap_y=279; tries cleared, so the next draw gets a full 4 tries.
- Pop boundaries:
  - Stimulus: pop with the FIFO empty; then a simultaneous push and pop with 1 entry held.
  - Required: empty pop does nothing. The simultaneous case keeps count=1, and the new head equals the pushed value on the following cycle.
- Flap and reset mid-operation:
  - Flap: flap=1 for 3 cycles gives change=1 for 3 cycles, delayed by 1.
  - Reset mid-operation: assert rst_n=0 during SKIPW with 2 entries queued. Required: gap_valid=0 immediately, and the FSM restarts from IDLE after release.
